// File: rtl/cpu_pkg.sv
// Shared CPU types: PC source select, exception cause and sequencer states.
// Also holds default reset PC, handler-vector base and memory latency.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCS_INC = 2'd0,
        PCS_BR  = 2'd1,
        PCS_JMP = 2'd2,
        PCS_JR  = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        EXC_INVOP = 2'd0,
        EXC_OVF   = 2'd1,
        EXC_DIV0  = 2'd2,
        EXC_RSVD  = 2'd3
    } exc_cause_e;

    typedef enum logic [1:0] {
        EXC_IDLE = 2'd0,
        EXC_ADDR = 2'd1,
        EXC_WAIT = 2'd2,
        EXC_LOAD = 2'd3
    } exc_state_e;

    localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_BASE_DEF = 32'd255;
    localparam int          MEM_LAT_DEF      = 1;

    // Reserved cause shares the invalid-opcode handler.
    function automatic exc_cause_e norm_cause(input logic [1:0] c);
        return (c == 2'd3) ? EXC_INVOP : exc_cause_e'(c);
    endfunction

endpackage

// File: rtl/pc_exc_seq.sv
// Exception sequencer: FSM, memory wait counter and latched cause.
// Ports: clk, rst_n, exc_req, exc_cause in; exc_busy, exc_mem_addr, exc_mem_rd, load_vec out.
module pc_exc_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC_BASE = EXC_VEC_BASE_DEF,
    parameter int          MEM_LAT      = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    output logic        exc_busy,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_rd,
    output logic        load_vec
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    exc_state_e state_q, state_d;
    exc_cause_e cause_q, cause_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       rd_q, rd_d;
    logic       ldv_q, ldv_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rd_d    = rd_q;
        ldv_d   = 1'b0;
        unique case (state_q)
            EXC_IDLE: begin
                if (exc_req) begin
                    state_d = EXC_ADDR;
                    cause_d = norm_cause(exc_cause);
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                end
            end
            EXC_ADDR: begin
                state_d = EXC_WAIT;
                cnt_d   = 3'd0;
            end
            EXC_WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_d = EXC_LOAD;
                    rd_d    = 1'b0;
                    ldv_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            EXC_LOAD: begin
                state_d = EXC_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EXC_IDLE;
            cause_q <= EXC_INVOP;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            ldv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            ldv_q   <= ldv_d;
        end
    end

    assign exc_busy     = busy_q;
    assign exc_mem_rd   = rd_q;
    assign load_vec     = ldv_q;
    assign exc_mem_addr = rd_q ? (EXC_VEC_BASE - {30'd0, cause_q}) : 32'd0;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC mux, PC and EPC registers, exception sequencer.
// Ports: control/data inputs, mem_data in; pc, epc, exc_mem_addr, exc_mem_rd, exc_busy, align_err out.
// Optional: PC_ALIGN_CHECK_EN suppresses misaligned normal loads and flags align_err.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC_BASE = EXC_VEC_BASE_DEF,
    parameter int          MEM_LAT      = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_taken,
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_a,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [7:0]  mem_data,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_rd,
    output logic        exc_busy,
    output logic        align_err
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target;
    logic        load_vec;
    logic        exc_start;
    logic        ld_req;
    logic        ld_ok;

    pc_exc_seq #(
        .EXC_VEC_BASE(EXC_VEC_BASE),
        .MEM_LAT     (MEM_LAT)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_req     (exc_req),
        .exc_cause   (exc_cause),
        .exc_busy    (exc_busy),
        .exc_mem_addr(exc_mem_addr),
        .exc_mem_rd  (exc_mem_rd),
        .load_vec    (load_vec)
    );

    always_comb begin
        target = alu_result;
        unique case (pc_src_e'(pc_src))
            PCS_INC: target = alu_result;
            PCS_BR:  target = alu_out;
            PCS_JMP: target = jump_target;
            PCS_JR:  target = reg_a;
        endcase
    end

    // An accepted exception request drops a same-cycle PC load.
    assign exc_start = exc_req & ~exc_busy;
    assign ld_req    = (pc_write | (pc_write_cond & branch_taken))
                       & ~exc_busy & ~exc_req;

`ifdef PC_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;
    logic misalign;

    assign misalign    = |target[1:0];
    assign ld_ok       = ld_req & ~misalign;
    assign align_err_d = ld_req & misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) align_err_q <= 1'b0;
        else        align_err_q <= align_err_d;
    end

    assign align_err = align_err_q;
`else
    assign ld_ok     = ld_req;
    assign align_err = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (load_vec)
            pc_d = {24'd0, mem_data};
        else if (ld_ok)
            pc_d = target;
        if (exc_start)
            epc_d = pc_q - 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            epc_q <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    assign pc  = pc_q;
    assign epc = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized self-checking bench for pc_unit against a cycle-count reference model.
// Directed spec scenarios first, then random traffic.
module tb_pc_unit;

    localparam int MEM_LAT = 1;
    localparam logic [31:0] VEC = 32'd255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, pc_write_cond, branch_taken;
    logic [1:0]  pc_src;
    logic [31:0] alu_result, alu_out, jump_target, reg_a;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_data;
    logic [31:0] pc, epc, exc_mem_addr;
    logic        exc_mem_rd, exc_busy, align_err;

    int errs = 0;
    int checks = 0;

    // Reference model: seq counts cycles since an accepted exception
    // (0 = none running); the handler byte loads at seq == 2+MEM_LAT.
    logic [31:0] m_pc, m_epc;
    int          m_seq, m_cause;
    logic        m_aerr;

    always #5 clk = ~clk;

    pc_unit #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_taken(branch_taken), .pc_src(pc_src),
        .alu_result(alu_result), .alu_out(alu_out),
        .jump_target(jump_target), .reg_a(reg_a),
        .exc_req(exc_req), .exc_cause(exc_cause),
        .mem_data(mem_data), .pc(pc), .epc(epc),
        .exc_mem_addr(exc_mem_addr), .exc_mem_rd(exc_mem_rd),
        .exc_busy(exc_busy), .align_err(align_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        rst_n = 1'b1; pc_write = 0; pc_write_cond = 0; branch_taken = 0;
        pc_src = 2'd0; exc_req = 0; exc_cause = 2'd0;
    endtask

    function automatic logic [31:0] sel_target();
        case (pc_src)
            2'd0: return alu_result;
            2'd1: return alu_out;
            2'd2: return jump_target;
            default: return reg_a;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] t;
        m_aerr = 1'b0;
        if (!rst_n) begin
            m_pc = 32'd0; m_epc = 32'd0; m_seq = 0; m_cause = 0;
        end else if (m_seq == 0) begin
            if (exc_req) begin
                m_epc   = m_pc - 32'd4;
                m_cause = (exc_cause == 2'd3) ? 0 : int'(exc_cause);
                m_seq   = 1;
            end else if (pc_write || (pc_write_cond && branch_taken)) begin
                t = sel_target();
`ifdef PC_ALIGN_CHECK_EN
                if (t % 4 != 0) m_aerr = 1'b1;
                else m_pc = t;
`else
                m_pc = t;
`endif
            end
        end else if (m_seq == 2 + MEM_LAT) begin
            m_pc  = 32'(mem_data);
            m_seq = 0;
        end else begin
            m_seq++;
        end
    endtask

    task automatic step();
        bit rd;
        model_edge();
        @(posedge clk);
        #1;
        rd = (m_seq >= 1) && (m_seq <= 1 + MEM_LAT);
        chk("pc", pc, m_pc);
        chk("epc", epc, m_epc);
        chk("busy", 32'(exc_busy), 32'(m_seq != 0));
        chk("mem_rd", 32'(exc_mem_rd), 32'(rd));
        chk("mem_addr", exc_mem_addr, rd ? VEC - 32'(m_cause) : 32'd0);
        chk("align_err", 32'(align_err), 32'(m_aerr));
    endtask

    initial begin
        logic [31:0] r;
        idle_in();
        alu_result = 0; alu_out = 0; jump_target = 0; reg_a = 0;
        mem_data = 8'hA0;
        m_pc = 32'hDEAD_BEEF; m_epc = 0; m_seq = 0; m_cause = 0; m_aerr = 0;

        // 1. reset
        rst_n = 0;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_busy", 32'(exc_busy), 32'h0);
        idle_in();

        // 2. unconditional loads
        pc_write = 1; alu_result = 32'h4; step();
        chk("inc_pc", pc, 32'h4);
        pc_src = 2'd2; jump_target = 32'h0040_0020; step();
        chk("jmp_pc", pc, 32'h0040_0020);
        idle_in(); step();
        chk("hold_pc", pc, 32'h0040_0020);

        // 3. conditional branch
        pc_write_cond = 1; pc_src = 2'd1; alu_out = 32'h100; step();
        chk("br_nt", pc, 32'h0040_0020);
        branch_taken = 1; step();
        chk("br_t", pc, 32'h100);
        idle_in();

        // 4. exception sequence
        pc_write = 1; alu_result = 32'h18; step();
        idle_in(); exc_req = 1; exc_cause = 2'd1; step();
        chk("exc_epc", epc, 32'h14);
        chk("exc_addr1", exc_mem_addr, 32'd254);
        idle_in(); step();
        chk("exc_addr2", exc_mem_addr, 32'd254);
        step(); step();
        chk("exc_pc", pc, 32'hA0);
        chk("exc_done", 32'(exc_busy), 32'h0);

        // 5. priority, busy-time request, abort by reset
        pc_write = 1; alu_result = 32'h40; exc_req = 1; exc_cause = 2'd3; step();
        chk("prio_pc", pc, 32'hA0);
        chk("prio_addr", exc_mem_addr, 32'd255);
        idle_in(); step();
        exc_req = 1; exc_cause = 2'd2; pc_write = 1; step();
        idle_in(); mem_data = 8'h5C; step();
        chk("ign_pc", pc, 32'h5C);
        exc_req = 1; step(); idle_in(); step();
        rst_n = 0; step();
        chk("abort_pc", pc, 32'h0);
        chk("abort_busy", 32'(exc_busy), 32'h0);
        idle_in();

        // 6. misaligned jr target
        pc_write = 1; pc_src = 2'd3; reg_a = 32'h102; step();
`ifdef PC_ALIGN_CHECK_EN
        chk("al_pc", pc, 32'h0);
        chk("al_err", 32'(align_err), 32'h1);
        idle_in(); step();
        chk("al_err_pulse", 32'(align_err), 32'h0);
`else
        chk("al_pc", pc, 32'h102);
        chk("al_err", 32'(align_err), 32'h0);
`endif
        idle_in();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = $urandom_range(0, 1) == 1;
            branch_taken  = $urandom_range(0, 1) == 1;
            pc_src        = 2'($urandom_range(0, 3));
            exc_req       = ($urandom_range(0, 7) == 0);
            exc_cause     = 2'($urandom_range(0, 3));
            mem_data      = 8'($urandom_range(0, 255));
            r = $urandom();
            alu_result = (r & 32'hFFFF_FFFC) | 32'($urandom_range(0, 7) == 0);
            r = $urandom();
            alu_out = r & 32'hFFFF_FFFC;
            r = $urandom();
            jump_target = r & 32'hFFFF_FFFC;
            r = $urandom();
            reg_a = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
